// File: rtl/alu_issue_ctrl.sv
// Issue controller for one type-2 ALU: latches a container vector and action word, issues the action, waits for the result and writes it into cont[dst].
// Optional build macro ALU_ISSUE_BYPASS_EN: when defined, opcode 0000 skips the ALU and returns the vector unmodified.
module alu_issue_ctrl #(
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CONT   = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_CONT*DATA_WIDTH-1:0] cont_vec_in,
    input  logic [ACTION_LEN-1:0]          action_in,
    output logic [ACTION_LEN-1:0]          alu_action,
    output logic                           alu_action_valid,
    output logic [DATA_WIDTH-1:0]          alu_operand_1,
    output logic [DATA_WIDTH-1:0]          alu_operand_2,
    output logic [DATA_WIDTH-1:0]          alu_operand_3,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_result_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_CONT*DATA_WIDTH-1:0] cont_vec_out,
    output logic                           timeout_err,
    output logic [15:0]                    timeout_cnt
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_OUT
    } state_t;

    state_t                  state_reg;
    logic [WAIT_W-1:0]       wait_cnt_reg;
    logic [2:0]              dst_reg;
    logic [DATA_WIDTH-1:0]   cont_reg [NUM_CONT];
    logic [DATA_WIDTH-1:0]   cont_in  [NUM_CONT];

    logic [2:0]              dst_in;
    logic [2:0]              src1_in;
    logic [2:0]              src2_in;
    logic [14:0]             imm_in;
    logic [DATA_WIDTH-1:0]   op2_next;
    logic                    accept;
    logic                    bypass_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CONT; gi++) begin : g_cont
            assign cont_in[gi] = cont_vec_in[gi*DATA_WIDTH +: DATA_WIDTH];
            assign cont_vec_out[gi*DATA_WIDTH +: DATA_WIDTH] = cont_reg[gi];
        end
    endgenerate

    // The src2 and immediate fields overlap; op[3] selects which reading applies.
    assign dst_in   = action_in[20:18];
    assign src1_in  = action_in[17:15];
    assign src2_in  = action_in[14:12];
    assign imm_in   = action_in[14:0];
    assign op2_next = action_in[24] ? {{(DATA_WIDTH-15){1'b0}}, imm_in} : cont_in[src2_in];
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_BYPASS_EN
    assign bypass_hit = (action_in[24:21] == 4'b0000);
`else
    assign bypass_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            wait_cnt_reg     <= '0;
            dst_reg          <= '0;
            in_ready         <= 1'b1;
            out_valid        <= 1'b0;
            alu_action       <= '0;
            alu_action_valid <= 1'b0;
            alu_operand_1    <= '0;
            alu_operand_2    <= '0;
            alu_operand_3    <= '0;
            timeout_err      <= 1'b0;
            timeout_cnt      <= '0;
            for (int i = 0; i < NUM_CONT; i++) begin
                cont_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        // Operands are taken from the incoming vector, before any write-back.
                        for (int i = 0; i < NUM_CONT; i++) begin
                            cont_reg[i] <= cont_in[i];
                        end
                        dst_reg       <= dst_in;
                        alu_action    <= action_in;
                        alu_operand_1 <= cont_in[src1_in];
                        alu_operand_2 <= op2_next;
                        alu_operand_3 <= cont_in[dst_in];
                        in_ready      <= 1'b0;
                        if (bypass_hit) begin
                            state_reg   <= ST_OUT;
                            out_valid   <= 1'b1;
                            timeout_err <= 1'b0;
                        end else begin
                            state_reg        <= ST_ISSUE;
                            alu_action_valid <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    alu_action_valid <= 1'b0;
                    wait_cnt_reg     <= '0;
                    state_reg        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A result on the limit cycle still wins over the timeout.
                    if (alu_result_valid) begin
                        cont_reg[dst_reg] <= alu_result;
                        timeout_err       <= 1'b0;
                        out_valid         <= 1'b1;
                        state_reg         <= ST_OUT;
                    end else if (wait_cnt_reg == WAIT_LAST) begin
                        timeout_err <= 1'b1;
                        if (timeout_cnt != 16'hFFFF) begin
                            timeout_cnt <= timeout_cnt + 16'd1;
                        end
                        out_valid <= 1'b1;
                        state_reg <= ST_OUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small ALU responder and a transaction-level reference model.
module tb_alu_issue_ctrl;
    localparam int AL = 25;
    localparam int DW = 32;
    localparam int NC = 8;
    localparam int TO = 15;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [NC*DW-1:0] cont_vec_in = '0;
    logic [AL-1:0]    action_in = '0;
    logic [AL-1:0]    alu_action;
    logic             alu_action_valid;
    logic [DW-1:0]    alu_operand_1, alu_operand_2, alu_operand_3;
    logic [DW-1:0]    alu_result = '0;
    logic             alu_result_valid = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [NC*DW-1:0] cont_vec_out;
    logic             timeout_err;
    logic [15:0]      timeout_cnt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.ACTION_LEN(AL), .DATA_WIDTH(DW), .NUM_CONT(NC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .cont_vec_in(cont_vec_in), .action_in(action_in),
        .alu_action(alu_action), .alu_action_valid(alu_action_valid),
        .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2), .alu_operand_3(alu_operand_3),
        .alu_result(alu_result), .alu_result_valid(alu_result_valid),
        .out_valid(out_valid), .out_ready(out_ready), .cont_vec_out(cont_vec_out),
        .timeout_err(timeout_err), .timeout_cnt(timeout_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference expectations for the transaction in flight
    logic [DW-1:0]    exp_op1, exp_op2, exp_op3;
    logic [AL-1:0]    exp_act;
    logic [NC*DW-1:0] exp_vec;
    logic             exp_to;
    logic [15:0]      exp_tcnt = '0;
    logic [DW-1:0]    ref_mem [16];
    bit               txn_active = 1'b0;
    int               issue_seen = 0;
    logic [DW-1:0]    cap_op1, cap_op2, cap_op3;
    logic [NC*DW-1:0] last_vec;
    int               acc_wait;

    // ALU responder controls
    int               alu_lat = -1;
    int               stray_req = 0;
    logic [DW-1:0]    alu_mem [16];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] alu_calc(input logic [3:0] op, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b, input logic [DW-1:0] c,
                                               input logic [DW-1:0] m);
        case (op)
            4'b0001, 4'b1001: return a + b;
            4'b0010, 4'b1010: return a - b;
            4'b1011:          return m;
            default:          return c;
        endcase
    endfunction

    function automatic logic [AL-1:0] mk_r(input logic [3:0] op, input int d, input int s1, input int s2);
        return {op, 3'(d), 3'(s1), 3'(s2), 12'h000};
    endfunction

    function automatic logic [AL-1:0] mk_i(input logic [3:0] op, input int d, input int s1, input int imm);
        return {op, 3'(d), 3'(s1), 15'(imm)};
    endfunction

    // ALU model: returns its result alu_lat+1 cycles after the issue cycle; alu_lat<0 never answers.
    int            countdown = 0;
    int            stray_done = 0;
    logic [DW-1:0] pend = '0;
    always @(negedge clk) begin
        alu_result_valid = 1'b0;
        if (rst) begin
            countdown = 0;
        end else begin
            if (stray_req != stray_done) begin
                stray_done       = stray_req;
                alu_result_valid = 1'b1;
                alu_result       = 32'hBAD0BAD0;
            end
            if (countdown > 0) begin
                countdown--;
                if (countdown == 0) begin
                    alu_result_valid = 1'b1;
                    alu_result       = pend;
                end
            end
            if (alu_action_valid && alu_lat >= 0) begin
                pend = alu_calc(alu_action[24:21], alu_operand_1, alu_operand_2, alu_operand_3,
                                alu_mem[alu_operand_2[3:0]]);
                if (alu_action[24:21] == 4'b1000) alu_mem[alu_operand_2[3:0]] = alu_operand_1;
                countdown = alu_lat + 1;
            end
        end
    end

    // Per-cycle compare against the reference expectations
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready_valid_excl", {255'b0, in_ready & out_valid}, 256'b0);
            if (alu_action_valid) begin
                issue_seen++;
                cap_op1 = alu_operand_1;
                cap_op2 = alu_operand_2;
                cap_op3 = alu_operand_3;
            end
            if (txn_active) begin
                chk("op1", alu_operand_1, exp_op1);
                chk("op2", alu_operand_2, exp_op2);
                chk("op3", alu_operand_3, exp_op3);
                chk("action", alu_action, exp_act);
            end
            if (out_valid) begin
                chk("vec_out", cont_vec_out, exp_vec);
                chk("timeout_err", timeout_err, exp_to);
                chk("timeout_cnt", timeout_cnt, exp_tcnt);
            end
        end
    end

    task automatic send(input logic [NC*DW-1:0] vec, input logic [AL-1:0] act, input int lat,
                        input int hold, output int meas);
        logic [3:0]    op;
        int            d, s1, s2, explat, base;
        bit            byp, timed;
        logic [DW-1:0] res;
        op = act[24:21];
        d  = int'(act[20:18]);
        s1 = int'(act[17:15]);
        s2 = int'(act[14:12]);
        byp = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
        byp = (op == 4'b0000);
`endif
        timed   = !byp && (lat < 0 || lat > TO - 1);
        exp_op1 = vec[s1*DW +: DW];
        exp_op2 = op[3] ? {17'b0, act[14:0]} : vec[s2*DW +: DW];
        exp_op3 = vec[d*DW +: DW];
        exp_act = act;
        res     = alu_calc(op, exp_op1, exp_op2, exp_op3, ref_mem[exp_op2[3:0]]);
        if (!byp && lat >= 0 && op == 4'b1000) ref_mem[exp_op2[3:0]] = exp_op1;
        exp_vec = vec;
        if (!byp && !timed) exp_vec[d*DW +: DW] = res;
        exp_to = timed;
        if (timed) exp_tcnt = exp_tcnt + 16'd1;
        explat = byp ? 1 : (timed ? TO + 1 : lat + 2);
        alu_lat = byp ? -1 : lat;

        acc_wait = 0;
        @(negedge clk);
        while (!in_ready && acc_wait < 50) begin
            @(negedge clk);
            acc_wait++;
        end
        chk("in_ready_seen", in_ready, 1'b1);
        in_valid    = 1'b1;
        cont_vec_in = vec;
        action_in   = act;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        base       = issue_seen;
        txn_active = 1'b1;

        meas = 0;
        while (!out_valid && meas < 40) begin
            @(posedge clk);
            #1;
            meas++;
        end
        chk("out_valid_seen", out_valid, 1'b1);
        chk("latency", meas, explat);
        for (int i = 0; i < hold; i++) begin
            if (i == 0) stray_req++;
            @(posedge clk);
            #1;
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        last_vec  = cont_vec_out;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready  = 1'b0;
        txn_active = 1'b0;
        chk("post_hs_valid", out_valid, 1'b0);
        chk("post_hs_ready", in_ready, 1'b1);
        chk("issue_pulses", issue_seen - base, byp ? 0 : 1);
        $display("txn op=%b dst=%0d lat=%0d hold=%0d latency=%0d to=%0b", op, d, lat, hold, meas, timed);
    endtask

    initial begin
        logic [NC*DW-1:0] v;
        int m;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = '0;
            alu_mem[i] = '0;
        end
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = 32'h0A000000 + 32'(i);
        v[1*DW +: DW] = 32'd5;
        v[2*DW +: DW] = 32'd7;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_issue", alu_action_valid, 1'b0);
        chk("rst_vec", cont_vec_out, 256'b0);
        chk("rst_tcnt", timeout_cnt, 16'd0);
        chk("rst_op1", alu_operand_1, 32'd0);
        rst = 1'b0;

        send(v, mk_r(4'b0001, 3, 1, 2), 3, 0, m);
        chk("add_latency", m, 5);
        chk("add_op1", cap_op1, 32'd5);
        chk("add_op2", cap_op2, 32'd7);
        chk("add_dst", last_vec[3*DW +: DW], 32'd12);
        chk("add_c0_kept", last_vec[0 +: DW], 32'h0A000000);

        v[4*DW +: DW] = 32'hDEADBEEF;
        v[5*DW +: DW] = 32'h55;
        send(v, mk_i(4'b1000, 5, 4, 3), 2, 0, m);
        chk("st_op1", cap_op1, 32'hDEADBEEF);
        chk("st_op2", cap_op2, 32'd3);
        chk("st_op3", cap_op3, 32'h55);
        chk("st_dst_kept", last_vec[5*DW +: DW], 32'h55);

        send(v, mk_i(4'b1011, 0, 0, 3), 3, 0, m);
        chk("ld_dst", last_vec[0 +: DW], 32'hDEADBEEF);

        send(v, mk_r(4'b0010, 2, 2, 6), 1, 0, m);
        chk("sub_dst", last_vec[2*DW +: DW], 32'hF6000001);

        send(v, mk_i(4'b1001, 7, 7, 32'h7FFF), 0, 0, m);
        chk("addi_latency", m, 2);
        chk("addi_dst", last_vec[7*DW +: DW], 32'h0A008006);

        send(v, mk_r(4'b0001, 3, 1, 2), -1, 4, m);
        chk("to_latency", m, 16);
        chk("to_cnt", timeout_cnt, 16'd1);
        chk("to_dst_kept", last_vec[3*DW +: DW], 32'h0A000003);

        send(v, mk_r(4'b0001, 3, 1, 2), 14, 0, m);
        chk("tie_dst", last_vec[3*DW +: DW], 32'd12);
        chk("tie_cnt", timeout_cnt, 16'd1);

        send(v, mk_r(4'b0001, 3, 1, 2), 15, 0, m);
        chk("late_cnt", timeout_cnt, 16'd2);

        send(v, mk_r(4'b0001, 3, 1, 2), 3, 10, m);
        send(v, mk_r(4'b0010, 1, 2, 1), 3, 0, m);
        chk("b2b_wait", acc_wait, 0);
        chk("b2b_dst", last_vec[1*DW +: DW], 32'd2);

        send(v, mk_r(4'b0000, 3, 1, 2), 3, 0, m);
`ifdef ALU_ISSUE_BYPASS_EN
        chk("byp_latency", m, 1);
`else
        chk("byp_latency", m, 5);
`endif
        chk("byp_dst", last_vec[3*DW +: DW], 32'h0A000003);

        // Reset while waiting on an ALU that never answers
        alu_lat = -1;
        @(negedge clk);
        in_valid    = 1'b1;
        cont_vec_in = v;
        action_in   = mk_r(4'b0001, 3, 1, 2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rw_busy", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        exp_tcnt = '0;
        stray_req++;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("rw_out_valid", out_valid, 1'b0);
            chk("rw_in_ready", in_ready, 1'b1);
            chk("rw_issue", alu_action_valid, 1'b0);
            chk("rw_tcnt", timeout_cnt, 16'd0);
            chk("rw_vec", cont_vec_out, 256'b0);
            chk("rw_op1", alu_operand_1, 32'd0);
            chk("rw_err", timeout_err, 1'b0);
        end
        $display("txn reset-in-wait done");

        send(v, mk_r(4'b0001, 3, 1, 2), 3, 0, m);
        chk("recover_dst", last_vec[3*DW +: DW], 32'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Drives one type-2 ALU (load/store capable) from the action side.
- Accepts a container vector and a 25-bit action word, then decodes the opcode and the container selectors.
- Issues a single-cycle action with three operands to the ALU, waits for the ALU's registered result, and writes it into the destination container.
- Presents the updated container vector downstream. It sits between the per-stage action fetch and the ALU, one instance per ALU.

Parameters:
- ACTION_LEN, 25, action word width; opcode at [24:21].
- DATA_WIDTH, 32, container/operand width.
- NUM_CONT, 8, containers in the vector; index fields are 3 bits.
- TIMEOUT, 15, maximum WAIT cycles before abandoning the action.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  container vector + action valid
- in_ready  out  1  high only in IDLE
- cont_vec_in  in  NUM_CONT*DATA_WIDTH  container i at [i*DATA_WIDTH +: DATA_WIDTH]
- action_in  in  ACTION_LEN  [24:21] op, [20:18] dst, [17:15] src1, [14:12] src2, [14:0] imm
- alu_action  out  ACTION_LEN  action to ALU
- alu_action_valid  out  1  one-cycle issue pulse
- alu_operand_1  out  DATA_WIDTH
- alu_operand_2  out  DATA_WIDTH
- alu_operand_3  out  DATA_WIDTH
- alu_result  in  DATA_WIDTH  ALU container output
- alu_result_valid  in  1  ALU result strobe
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accept
- cont_vec_out  out  NUM_CONT*DATA_WIDTH  updated vector
- timeout_err  out  1  current output's action timed out
- timeout_cnt  out  16  saturating count of timeouts

Behaviour:
- Reset: state IDLE; every output 0 except in_ready=1; timeout_cnt=0.
  - Reset mid-operation abandons the held action.
  - An alu_result_valid arriving after reset is ignored, because it arrives outside WAIT.
- Operand formation, registered on the accept cycle (in_valid & in_ready):
  - op1 = cont[src1].
  - op2 = cont[src2] when op[3]=0; otherwise {zeros, imm[14:0]} (addi 1001, subi 1010, store 1000, load 1011).
  - op3 = cont[dst], always.
  - The full vector and dst are latched on the same cycle.
- FSM:
  - IDLE: in_ready=1. On accept, go to ISSUE.
  - ISSUE: alu_action_valid=1 for exactly this cycle; action and operands are stable. Go to WAIT, wait_cnt=0.
  - WAIT: alu_action_valid=0; operand outputs hold their values.
    - On alu_result_valid: cont[dst] <= alu_result, timeout_err <= 0, go to OUT.
    - Otherwise, if wait_cnt == TIMEOUT-1: cont[dst] unchanged, timeout_err <= 1, timeout_cnt += 1 (saturates at 0xFFFF), go to OUT.
    - Otherwise wait_cnt increments.
  - OUT: out_valid=1; cont_vec_out and timeout_err are held stable until out_ready. On out_valid & out_ready, go to IDLE with out_valid=0 on the next cycle.
- Throughput: one action in flight; new input is accepted no earlier than the cycle after the OUT handshake.
- Latency: for an ALU result 3 cycles after issue, out_valid rises 5 cycles after the accept edge.
- alu_result_valid outside WAIT is ignored and does not alter state or data.
- A result and the timeout limit in the same cycle: the result wins, and no timeout is counted.
- dst equal to src1 or src2 is legal. Operands come from the pre-update vector.
- No arithmetic is done here; the vector is carried unchanged except at cont[dst].

Optional Feature:
- ALU_ISSUE_BYPASS_EN:
  - Defined: opcode 0000 skips ISSUE and WAIT. Accept goes straight to OUT with the vector unmodified, timeout_err=0, and no alu_action_valid pulse.
  - Undefined: opcode 0000 is issued like any other action, and the ALU's default path returns cont[dst].

Test Plan:
- Add: cont[1]=5, cont[2]=7, action op=0001 dst=3 src1=1 src2=2, ALU model latency 3 -> alu_operand_1=5, alu_operand_2=7, one-cycle alu_action_valid; cont_vec_out[3]=12, other containers unchanged, timeout_err=0.
- Store/load immediate: op=1000 src1=4 (cont[4]=0xDEADBEEF) imm=3 -> alu_operand_2=3, alu_operand_3=cont[dst]; then op=1011 imm=3 dst=0 with the model returning 0xDEADBEEF -> cont_vec_out[0]=0xDEADBEEF.
- Timeout: ALU model never responds -> out_valid rises after 15 WAIT cycles, timeout_err=1, cont[dst] unchanged, timeout_cnt=1; a late alu_result_valid afterwards is ignored.
- Backpressure: out_ready held low for 10 cycles -> out_valid and cont_vec_out stable, in_ready=0 throughout; a second action is accepted the cycle after the handshake.
- Reset in WAIT: assert rst for 1 cycle, then a stray alu_result_valid -> all outputs 0, in_ready=1, no out_valid.
- Bypass, macro defined: op=0000 -> no alu_action_valid, out_valid 1 cycle after accept, vector unchanged; macro undefined -> issue pulse seen, cont[dst] = returned op3.
